// File: rtl/lathe_input_conditioner_if.sv
// Panel-to-timer-stage signal bundle for the lathe input conditioner.
// master drives the raw contacts and ena; slave is the conditioner itself.
interface lathe_input_conditioner_if;
  logic       ena;
  logic       raw_start;
  logic       raw_auto;
  logic       raw_man;
  logic       raw_estop_n;
  logic       start_o;
  logic       auto_o;
  logic       man_o;
  logic       fault_o;
  logic [1:0] state_o;

  modport master (
    output ena, raw_start, raw_auto, raw_man, raw_estop_n,
    input  start_o, auto_o, man_o, fault_o, state_o
  );

  modport slave (
    input  ena, raw_start, raw_auto, raw_man, raw_estop_n,
    output start_o, auto_o, man_o, fault_o, state_o
  );
endinterface

// File: rtl/lathe_input_conditioner.sv
// Lathe operator-panel front end: 2-flop synchronizers, per-contact debounce,
// single-mode arbitration FSM with latched FAULT, registered clean outputs.
module lathe_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 24
) (
  input logic                       clk,
  input logic                       reset,
  lathe_input_conditioner_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_AUTO  = 2'd1,
    S_MAN   = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  // Bit order of the contact vectors: 0 start, 1 auto, 2 man, 3 estop_n.
  localparam logic [3:0] SYNC_RST = 4'b1000;

  logic [3:0]            sync1_q, sync1_d, sync2_q, sync2_d;
  logic [2:0]            db_q, db_d;
  logic [2:0][CNT_W-1:0] cnt_q, cnt_d;
  logic                  db_start_dly_q, db_start_dly_d;
  state_t                state_q, state_d;
  logic                  start_q, start_d, auto_q, auto_d, man_q, man_d, fault_q, fault_d;

  logic estop, start_rise, db_start, db_auto, db_man, illegal;

  assign db_start   = db_q[0];
  assign db_auto    = db_q[1];
  assign db_man     = db_q[2];
  assign estop      = ~sync2_q[3];
  assign start_rise = db_start & ~db_start_dly_q;
  assign illegal    = estop | (db_auto & db_man);

  // Synchronizer chain; everything freezes while ena is low.
  always_comb begin
    sync1_d        = sync1_q;
    sync2_d        = sync2_q;
    db_start_dly_d = db_start_dly_q;
    if (bus.ena) begin
      sync1_d        = {bus.raw_estop_n, bus.raw_man, bus.raw_auto, bus.raw_start};
      sync2_d        = sync1_q;
      db_start_dly_d = db_start;
    end
  end

  // Debounce: a level change must persist DEBOUNCE_CYCLES consecutive cycles.
  always_comb begin
    db_d  = db_q;
    cnt_d = cnt_q;
    if (bus.ena) begin
      for (int i = 0; i < 3; i++) begin
        if (sync2_q[i] != db_q[i]) begin
          if (cnt_q[i] == CNT_MAX) begin
            db_d[i]  = sync2_q[i];
            cnt_d[i] = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end else begin
          cnt_d[i] = '0;
        end
      end
    end
  end

  // Mode arbitration and output decode from the next state.
  always_comb begin
    state_d = state_q;
    if (bus.ena) begin
      unique case (state_q)
        S_IDLE: begin
          if (illegal)                   state_d = S_FAULT;
          else if (start_rise & db_auto) state_d = S_AUTO;
          else if (start_rise & db_man)  state_d = S_MAN;
        end
        S_AUTO: begin
          if (illegal)                   state_d = S_FAULT;
          else if (~db_start | ~db_auto) state_d = S_IDLE;
        end
        S_MAN: begin
          if (illegal)                   state_d = S_FAULT;
          else if (~db_start | ~db_man)  state_d = S_IDLE;
        end
        S_FAULT: begin
          if (~(estop | db_start | db_auto | db_man)) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
    start_d = (state_d == S_AUTO) | (state_d == S_MAN);
    auto_d  = (state_d == S_AUTO);
    man_d   = (state_d == S_MAN);
    fault_d = (state_d == S_FAULT);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q        <= SYNC_RST;
      sync2_q        <= SYNC_RST;
      db_q           <= '0;
      cnt_q          <= '0;
      db_start_dly_q <= 1'b0;
      state_q        <= S_IDLE;
      start_q        <= 1'b0;
      auto_q         <= 1'b0;
      man_q          <= 1'b0;
      fault_q        <= 1'b0;
    end else begin
      sync1_q        <= sync1_d;
      sync2_q        <= sync2_d;
      db_q           <= db_d;
      cnt_q          <= cnt_d;
      db_start_dly_q <= db_start_dly_d;
      state_q        <= state_d;
      start_q        <= start_d;
      auto_q         <= auto_d;
      man_q          <= man_d;
      fault_q        <= fault_d;
    end
  end

  assign bus.start_o = start_q;
  assign bus.auto_o  = auto_q;
  assign bus.man_o   = man_q;
  assign bus.fault_o = fault_q;
  assign bus.state_o = state_q;

endmodule

// File: doc/lathe_input_conditioner.md
# lathe_input_conditioner

Front-end stage for the lathe PLC controller. It synchronizes and debounces the raw operator panel contacts (start, AUTO, MAN, E-stop) and arbitrates a single legal operating mode. It then drives clean start/auto/man levels into the downstream on-delay timer/control stage. Illegal panel combinations and E-stop force a latched FAULT that the timer stage sees as "no start".

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable cycles required before a debounced level changes; legal range 1 to 2^24-1.
- `CNT_W`, default 24: width of each debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high reset, sampled on rising `clk`.
- `ena` in 1: when low, every register holds its value.
- `raw_start` in 1: panel start contact, asynchronous, active-high.
- `raw_auto` in 1: AUTO selector contact, asynchronous, active-high.
- `raw_man` in 1: MAN selector contact, asynchronous, active-high.
- `raw_estop_n` in 1: E-stop normally-closed loop, asynchronous; low means stop.
- `start_o` out 1: clean start to the timer stage.
- `auto_o` out 1: clean AUTO to the timer stage.
- `man_o` out 1: clean MAN to the timer stage.
- `fault_o` out 1: high while in FAULT.
- `state_o` out 2: FSM state code; IDLE=0, AUTO=1, MAN=2, FAULT=3.

## Operation

- **Synchronizers.**
  - Each raw input passes through a 2-flop synchronizer.
  - start/auto/man flops reset to 0. The estop_n flops reset to 1, so reset alone never causes a FAULT.
- **Debounce** (start, auto, man; one counter each):
  - If the synced value differs from the debounced value: when cnt == DEBOUNCE_CYCLES-1, debounced <= synced and cnt <= 0; otherwise cnt++.
  - If the synced value equals the debounced value, cnt <= 0. Any glitch therefore restarts the count.
  - E-stop is not debounced. `estop = ~synced_estop_n`.
- **Start edge.** `start_rise = db_start & ~db_start_q`, where `db_start_q` is the debounced start delayed one cycle. `db_start_q` resets to 0.
- **FSM.** All outputs are registered, decoded from the next state. Priority within each state is listed in order.
  - IDLE:
    - estop, or db_auto & db_man → FAULT.
    - start_rise & db_auto → AUTO.
    - start_rise & db_man → MAN.
    - Otherwise stay in IDLE.
  - AUTO:
    - estop, or db_auto & db_man → FAULT.
    - ~db_start, or ~db_auto → IDLE. A mode switch never goes directly to MAN.
    - Otherwise stay in AUTO.
  - MAN: mirror of AUTO with auto and man swapped.
  - FAULT:
    - Stay while estop, db_start, db_auto or db_man is high.
    - Go to IDLE only when all four are low in the same cycle.
- **Output decode:**
  - IDLE: all outputs 0.
  - AUTO: start_o=1, auto_o=1.
  - MAN: start_o=1, man_o=1.
  - FAULT: fault_o=1; start_o, auto_o and man_o are 0.
  - auto_o and man_o are never high together.
- **Start held through fault recovery.** Leaving FAULT requires start released. A new start edge is then needed, so there is no auto-restart.

## Timing

- **Reset values.** All outputs are 0 and state_o=0 one edge after reset is sampled high. All debounce counters and debounced levels are 0. Reset mid-operation (e.g. in AUTO with counters mid-count) takes effect on that edge, with the same values.
- **Debounced input latency.** Number the edge that first samples the new raw level as edge 1.
  - The debounced level changes at edge DEBOUNCE_CYCLES+2.
  - FSM outputs reflect it at edge DEBOUNCE_CYCLES+3.
- **E-stop latency.** E-stop asserted (raw_estop_n low) sets fault_o at edge 3, independent of DEBOUNCE_CYCLES.
- **ena.** ena low for k cycles delays all of the above latencies by exactly k edges; no state changes while ena is low.
- **Simultaneous debounced changes.** Changes landing on the same edge are evaluated together by the FSM priority above. For example, start and auto rising together from IDLE → AUTO.

## Test plan

Use DEBOUNCE_CYCLES=4 for all scenarios.

- **Reset.** Hold reset 2 cycles with all raw inputs high except estop_n=1 → all outputs 0, state_o=0 while reset is high.
- **AUTO entry.** raw_auto=1, then raw_start=1 after 10 cycles → start_o=auto_o=1 and state_o=1 exactly 7 edges after the start edge is first sampled. man_o stays 0.
- **Bounce rejection.** raw_man pulses high for 3 cycles, low 1, high 3 → man_o never asserts and state_o stays 0.
- **Illegal mode.** In MAN, raise raw_auto → fault_o=1, state_o=3 and start_o=0 at edge 7. Drop auto only → remain FAULT. Drop start and man too → IDLE. Re-press start with man → MAN.
- **E-stop.** In AUTO, drive raw_estop_n low for 1 cycle → fault_o=1 at edge 3. FAULT persists until estop_n is high and start/auto/man are all debounced low.
- **ena freeze.** Drop ena for 5 cycles mid-debounce → transition occurs 5 edges later than the ena=1 case.
